// File: rtl/nrisc_ctrl_pkg.sv
// nrisc_ctrl_pkg: state, opcode, mux-select and ALU encodings shared by the NRISC control unit and datapath
package nrisc_ctrl_pkg;

    typedef enum logic [2:0] {
        S_INIT   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_ADDI = 4'h4;
    localparam logic [3:0] OP_LW   = 4'h5;
    localparam logic [3:0] OP_SW   = 4'h6;
    localparam logic [3:0] OP_BEQ  = 4'h7;
    localparam logic [3:0] OP_JMP  = 4'h8;
    localparam logic [3:0] OP_JR   = 4'h9;
    localparam logic [3:0] OP_LI   = 4'hA;
    localparam logic [3:0] OP_JAL  = 4'hB;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [1:0] PC_INC = 2'd0;
    localparam logic [1:0] PC_BR  = 2'd1;
    localparam logic [1:0] PC_JMP = 2'd2;
    localparam logic [1:0] PC_REG = 2'd3;

    localparam logic [1:0] B_REG  = 2'd0;
    localparam logic [1:0] B_IMM  = 2'd1;
    localparam logic [1:0] B_ONE  = 2'd2;
    localparam logic [1:0] B_ZERO = 2'd3;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_IMM = 2'd2;
    localparam logic [1:0] WB_PC  = 2'd3;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;

    typedef struct packed {
        logic [1:0] pc_src_sel;
        logic [1:0] alu_b_sel;
        logic [1:0] wb_sel;
        logic [2:0] alu_op;
        logic       pc_we;
        logic       ir_we;
        logic       rf_we;
        logic       mem_re;
        logic       mem_we;
        logic       halted;
        logic       illegal;
    } ctrl_t;

    function automatic logic is_illegal(input logic [3:0] op);
        return op inside {4'hC, 4'hD, 4'hE};
    endfunction

    // register-register ALU ops and ADDI all go EXEC -> WB
    function automatic logic is_alu(input logic [3:0] op);
        return op <= OP_ADDI;
    endfunction

endpackage

// File: rtl/nrisc_ctrl_if.sv
// nrisc_ctrl_if: control unit <-> datapath/memory bundle
interface nrisc_ctrl_if;
    logic [3:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic [1:0] pc_src_sel;
    logic [1:0] alu_b_sel;
    logic [1:0] wb_sel;
    logic [2:0] alu_op;
    logic       pc_we;
    logic       ir_we;
    logic       rf_we;
    logic       mem_re;
    logic       mem_we;
    logic       halted;
    logic       illegal;
    logic [2:0] state;

    modport master (
        input  opcode, zero, mem_ready,
        output pc_src_sel, alu_b_sel, wb_sel, alu_op,
        output pc_we, ir_we, rf_we, mem_re, mem_we, halted, illegal, state
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  pc_src_sel, alu_b_sel, wb_sel, alu_op,
        input  pc_we, ir_we, rf_we, mem_re, mem_we, halted, illegal, state
    );
endinterface

// File: rtl/nrisc_ctrl_decode.sv
// nrisc_ctrl_decode: combinational output decode from state and opcode
module nrisc_ctrl_decode
    import nrisc_ctrl_pkg::*;
(
    input  state_t     state,
    input  logic [3:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output ctrl_t      ctrl
);

    // Moore decode; only FETCH strobes and the BEQ pc_we look at live inputs
    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_re = 1'b1;
                ctrl.ir_we  = mem_ready;
                ctrl.pc_we  = mem_ready;
            end
            S_DECODE: ctrl.illegal = is_illegal(op);
            S_EXEC: begin
                case (op)
                    OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                        ctrl.alu_b_sel = B_REG;
                        ctrl.alu_op    = {1'b0, op[1:0]};
                    end
                    OP_ADDI, OP_LW, OP_SW: begin
                        ctrl.alu_b_sel = B_IMM;
                        ctrl.alu_op    = ALU_ADD;
                    end
                    OP_BEQ: begin
                        ctrl.alu_b_sel  = B_REG;
                        ctrl.alu_op     = ALU_SUB;
                        ctrl.pc_src_sel = PC_BR;
                        ctrl.pc_we      = zero;
                    end
                    OP_JMP: begin
                        ctrl.pc_src_sel = PC_JMP;
                        ctrl.pc_we      = 1'b1;
                    end
                    OP_JR: begin
                        ctrl.pc_src_sel = PC_REG;
                        ctrl.pc_we      = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                ctrl.mem_re = op == OP_LW;
                ctrl.mem_we = op == OP_SW;
            end
            S_WB: begin
                ctrl.rf_we      = 1'b1;
                ctrl.wb_sel     = op == OP_LW  ? WB_MEM :
                                  op == OP_LI  ? WB_IMM :
                                  op == OP_JAL ? WB_PC  : WB_ALU;
                ctrl.pc_we      = op == OP_JAL;
                ctrl.pc_src_sel = op == OP_JAL ? PC_JMP : PC_INC;
            end
            S_HALT: ctrl.halted = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/nrisc_ctrl.sv
// nrisc_ctrl: multicycle control FSM for the 8-bit NRISC processor
module nrisc_ctrl
    import nrisc_ctrl_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    nrisc_ctrl_if.master bus
);

    state_t     state_q, state_d;
    logic [3:0] op_q;
    logic [3:0] op_cur;
    logic       armed;
    ctrl_t      ctrl;

    // DECODE acts on the live opcode; every later state uses the latched copy
    assign op_cur = state_q == S_DECODE ? bus.opcode : op_q;

    // state register, opcode latch, and a flag holding INIT for one full cycle after reset release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_INIT;
            op_q    <= '0;
            armed   <= 1'b0;
        end else begin
            state_q <= state_d;
            armed   <= 1'b1;
            if (state_q == S_DECODE) op_q <= bus.opcode;
        end
    end

    // next-state sequencing
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_INIT:   state_d = armed ? S_FETCH : S_INIT;
            S_FETCH:  state_d = bus.mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: state_d = op_cur inside {OP_LI, OP_JAL} ? S_WB     :
                                op_cur == OP_HALT             ? S_HALT   :
                                is_illegal(op_cur)            ? S_FETCH  : S_EXEC;
            S_EXEC:   state_d = is_alu(op_cur)                ? S_WB     :
                                op_cur inside {OP_LW, OP_SW}  ? S_MEM    : S_FETCH;
            S_MEM:    state_d = !bus.mem_ready                ? S_MEM    :
                                op_cur == OP_LW               ? S_WB     : S_FETCH;
            S_WB:     state_d = S_FETCH;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_INIT;
        endcase
    end

    nrisc_ctrl_decode u_decode (
        .state     (state_q),
        .op        (op_cur),
        .zero      (bus.zero),
        .mem_ready (bus.mem_ready),
        .ctrl      (ctrl)
    );

    assign bus.pc_src_sel = ctrl.pc_src_sel;
    assign bus.alu_b_sel  = ctrl.alu_b_sel;
    assign bus.wb_sel     = ctrl.wb_sel;
    assign bus.alu_op     = ctrl.alu_op;
    assign bus.pc_we      = ctrl.pc_we;
    assign bus.ir_we      = ctrl.ir_we;
    assign bus.rf_we      = ctrl.rf_we;
    assign bus.mem_re     = ctrl.mem_re;
    assign bus.mem_we     = ctrl.mem_we;
    assign bus.halted     = ctrl.halted;
    assign bus.illegal    = ctrl.illegal;
    assign bus.state      = state_q;

endmodule
